// File: rtl/market_trade_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : market_trade_sequencer_if
//  Purpose  : Sell-request valid/ready channel between player logic and the
//             market trade sequencer.
//  Revision : 1.0  initial release
// ============================================================================
interface market_trade_sequencer_if #(
   parameter int QTY_W = 8
);
   logic             sell_valid;
   logic             sell_ready;
   logic             sell_stock;
   logic [QTY_W-1:0] sell_amt;

   modport master (
      output sell_valid,
      output sell_stock,
      output sell_amt,
      input  sell_ready
   );

   modport slave (
      input  sell_valid,
      input  sell_stock,
      input  sell_amt,
      output sell_ready
   );
endinterface
`default_nettype wire

// File: rtl/market_trade_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : market_trade_sequencer
//  Purpose  : Owns two-stock market state (prices, holdings, cash), steps the
//             prices from an LFSR on each tick and commits player sell trades.
//             Optional macro MARKET_TRADE_STATS_EN adds trade counters.
//  Revision : 1.0  initial release
// ============================================================================
module market_trade_sequencer #(
   parameter int PRICE_W     = 12,
   parameter int QTY_W       = 8,
   parameter int CASH_W      = 24,
   parameter int FLUCT_BITS  = 5,
   parameter int UPPER_BOUND = 255,
   parameter int LOWER_BOUND = 1,
   parameter int INIT_PRICE  = 100,
   parameter int INIT_QTY    = 50,
   parameter int INIT_CASH   = 1000
) (
   input  wire logic               clock_50,
   input  wire logic               reset,
   input  wire logic               tick,
   market_trade_sequencer_if.slave sell_bus,
   output logic [PRICE_W-1:0]      price_a,
   output logic [PRICE_W-1:0]      price_b,
   output logic [QTY_W-1:0]        qty_a,
   output logic [QTY_W-1:0]        qty_b,
   output logic [CASH_W-1:0]       cash,
   output logic                    trade_done,
   output logic                    trade_reject,
   output logic                    price_upd,
   output logic                    tick_overrun
`ifdef MARKET_TRADE_STATS_EN
   ,
   output logic [15:0]             trades_ok,
   output logic [15:0]             trades_rej
`endif
);

   localparam logic [2:0] c_ST_IDLE    = 3'd0;
   localparam logic [2:0] c_ST_PRICE_A = 3'd1;
   localparam logic [2:0] c_ST_PRICE_B = 3'd2;
   localparam logic [2:0] c_ST_CHECK   = 3'd3;
   localparam logic [2:0] c_ST_COMMIT  = 3'd4;

   localparam logic [15:0] c_LFSR_SEED = 16'hACE1;

   localparam int c_PROD_W = QTY_W + PRICE_W;
   // One guard bit above the wider operand so the saturation compare sees overflow.
   localparam int c_SUM_W  = ((CASH_W > c_PROD_W) ? CASH_W : c_PROD_W) + 1;

   localparam logic [PRICE_W:0]   c_UPPER    = (PRICE_W+1)'(UPPER_BOUND);
   localparam logic [PRICE_W:0]   c_LOWER    = (PRICE_W+1)'(LOWER_BOUND);
   localparam logic [c_SUM_W-1:0] c_CASH_MAX = c_SUM_W'({CASH_W{1'b1}});

   logic [2:0]         r_state;
   logic [15:0]        r_lfsr;
   logic               r_tick_pend;
   logic               r_overrun;
   logic               r_sel_stock;
   logic [QTY_W-1:0]   r_sel_amt;
   logic [PRICE_W-1:0] r_price_a;
   logic [PRICE_W-1:0] r_price_b;
   logic [QTY_W-1:0]   r_qty_a;
   logic [QTY_W-1:0]   r_qty_b;
   logic [CASH_W-1:0]  r_cash;
   logic               r_trade_done;
   logic               r_trade_reject;
   logic               r_price_upd;

   logic                w_lfsr_fb;
   logic                w_sell_ready;
   logic [PRICE_W-1:0]  w_step_in;
   logic [PRICE_W-1:0]  w_step_out;
   logic [QTY_W-1:0]    w_sel_qty;
   logic [PRICE_W-1:0]  w_sel_price;
   logic                w_reject;
   logic                w_commit_now;
   logic                w_reject_now;
   logic [c_PROD_W-1:0] w_product;
   logic [c_SUM_W-1:0]  w_cash_sum;
   logic [CASH_W-1:0]   w_cash_next;

   // Random walk step; the extra MSB catches both underflow and overshoot.
   function automatic logic [PRICE_W-1:0] f_step(input logic [PRICE_W-1:0] price,
                                                 input logic [15:0]        lfsr);
      logic [PRICE_W:0] w_adj;
      logic [PRICE_W:0] w_res;
      w_adj = (PRICE_W+1)'(lfsr[FLUCT_BITS-1:0]);
      if (lfsr[15]) begin
         w_res = {1'b0, price} - w_adj;
         if (w_res[PRICE_W] || (w_res < c_LOWER))
            w_res = c_LOWER;
      end else begin
         w_res = {1'b0, price} + w_adj;
         if (w_res > c_UPPER)
            w_res = c_UPPER;
      end
      return w_res[PRICE_W-1:0];
   endfunction

   assign w_lfsr_fb    = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
   assign w_sell_ready = (r_state == c_ST_IDLE) && !tick && !r_tick_pend;

   assign w_step_in  = (r_state == c_ST_PRICE_A) ? r_price_a : r_price_b;
   assign w_step_out = f_step(w_step_in, r_lfsr);

   assign w_sel_qty   = r_sel_stock ? r_qty_b : r_qty_a;
   assign w_sel_price = r_sel_stock ? r_price_b : r_price_a;
   assign w_reject    = (r_sel_amt == '0) || (r_sel_amt > w_sel_qty);

   assign w_commit_now = (r_state == c_ST_COMMIT);
   assign w_reject_now = (r_state == c_ST_CHECK) && w_reject;

   assign w_product   = c_PROD_W'(r_sel_amt) * c_PROD_W'(w_sel_price);
   assign w_cash_sum  = c_SUM_W'(r_cash) + c_SUM_W'(w_product);
   assign w_cash_next = (w_cash_sum > c_CASH_MAX) ? {CASH_W{1'b1}} : w_cash_sum[CASH_W-1:0];

   always_ff @(posedge clock_50) begin
      if (reset) begin
         r_state        <= c_ST_IDLE;
         r_lfsr         <= c_LFSR_SEED;
         r_tick_pend    <= 1'b0;
         r_overrun      <= 1'b0;
         r_sel_stock    <= 1'b0;
         r_sel_amt      <= '0;
         r_price_a      <= PRICE_W'(INIT_PRICE);
         r_price_b      <= PRICE_W'(INIT_PRICE);
         r_qty_a        <= QTY_W'(INIT_QTY);
         r_qty_b        <= QTY_W'(INIT_QTY);
         r_cash         <= CASH_W'(INIT_CASH);
         r_trade_done   <= 1'b0;
         r_trade_reject <= 1'b0;
         r_price_upd    <= 1'b0;
      end else begin
         r_lfsr         <= {r_lfsr[14:0], w_lfsr_fb};
         r_trade_done   <= 1'b0;
         r_trade_reject <= 1'b0;
         r_price_upd    <= 1'b0;

         // Only one tick can wait; a second one while busy is lost.
         if (tick && (r_state != c_ST_IDLE)) begin
            if (r_tick_pend)
               r_overrun <= 1'b1;
            else
               r_tick_pend <= 1'b1;
         end

         case (r_state)
            c_ST_IDLE: begin
               if (tick || r_tick_pend) begin
                  r_tick_pend <= 1'b0;
                  r_state     <= c_ST_PRICE_A;
               end else if (sell_bus.sell_valid) begin
                  r_sel_stock <= sell_bus.sell_stock;
                  r_sel_amt   <= sell_bus.sell_amt;
                  r_state     <= c_ST_CHECK;
               end
            end
            c_ST_PRICE_A: begin
               r_price_a <= w_step_out;
               r_state   <= c_ST_PRICE_B;
            end
            c_ST_PRICE_B: begin
               r_price_b   <= w_step_out;
               r_price_upd <= 1'b1;
               r_state     <= c_ST_IDLE;
            end
            c_ST_CHECK: begin
               if (w_reject) begin
                  r_trade_reject <= 1'b1;
                  r_state        <= c_ST_IDLE;
               end else begin
                  r_state <= c_ST_COMMIT;
               end
            end
            c_ST_COMMIT: begin
               if (r_sel_stock)
                  r_qty_b <= r_qty_b - r_sel_amt;
               else
                  r_qty_a <= r_qty_a - r_sel_amt;
               r_cash       <= w_cash_next;
               r_trade_done <= 1'b1;
               r_state      <= c_ST_IDLE;
            end
            default: r_state <= c_ST_IDLE;
         endcase
      end
   end

`ifdef MARKET_TRADE_STATS_EN
   logic [15:0] r_trades_ok;
   logic [15:0] r_trades_rej;

   // Counters move on the same edge that raises the matching pulse.
   always_ff @(posedge clock_50) begin
      if (reset) begin
         r_trades_ok  <= '0;
         r_trades_rej <= '0;
      end else begin
         if (w_commit_now && (r_trades_ok != 16'hFFFF))
            r_trades_ok <= r_trades_ok + 16'd1;
         if (w_reject_now && (r_trades_rej != 16'hFFFF))
            r_trades_rej <= r_trades_rej + 16'd1;
      end
   end

   assign trades_ok  = r_trades_ok;
   assign trades_rej = r_trades_rej;
`else
   logic w_unused_stats;
   assign w_unused_stats = w_commit_now ^ w_reject_now;
`endif

   assign sell_bus.sell_ready = w_sell_ready;
   assign price_a      = r_price_a;
   assign price_b      = r_price_b;
   assign qty_a        = r_qty_a;
   assign qty_b        = r_qty_b;
   assign cash         = r_cash;
   assign trade_done   = r_trade_done;
   assign trade_reject = r_trade_reject;
   assign price_upd    = r_price_upd;
   assign tick_overrun = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_market_trade_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_market_trade_sequencer
//  Purpose  : Directed self-checking bench: main instance for trades and ticks,
//             plus high/low price-bound instances for long random-walk runs.
//  Revision : 1.0  initial release
// ============================================================================
module tb_market_trade_sequencer;

   localparam int c_CASH_MAX = 16777215;
   localparam int c_HI_CASH0 = 16757215;

   logic clock_50 = 1'b0;
   logic reset    = 1'b1;
   logic tick_m   = 1'b0;
   logic tick_x   = 1'b0;

   always #5 clock_50 = ~clock_50;

   market_trade_sequencer_if #(.QTY_W(8)) bus_m ();
   market_trade_sequencer_if #(.QTY_W(8)) bus_h ();
   market_trade_sequencer_if #(.QTY_W(8)) bus_l ();

   logic [11:0] pa_m, pb_m, pa_h, pb_h, pa_l, pb_l;
   logic [7:0]  qa_m, qb_m, qa_h, qb_h, qa_l, qb_l;
   logic [23:0] cash_m, cash_h, cash_l;
   logic        done_m, rej_m, upd_m, ovr_m;
   logic        done_h, rej_h, upd_h, ovr_h;
   logic        done_l, rej_l, upd_l, ovr_l;
`ifdef MARKET_TRADE_STATS_EN
   logic [15:0] ok_m, nrej_m, ok_h, nrej_h, ok_l, nrej_l;
`endif

   market_trade_sequencer u_dut (
      .clock_50(clock_50), .reset(reset), .tick(tick_m), .sell_bus(bus_m),
      .price_a(pa_m), .price_b(pb_m), .qty_a(qa_m), .qty_b(qb_m), .cash(cash_m),
      .trade_done(done_m), .trade_reject(rej_m), .price_upd(upd_m), .tick_overrun(ovr_m)
`ifdef MARKET_TRADE_STATS_EN
      , .trades_ok(ok_m), .trades_rej(nrej_m)
`endif
   );

   market_trade_sequencer #(.INIT_PRICE(255), .INIT_CASH(c_HI_CASH0)) u_hi (
      .clock_50(clock_50), .reset(reset), .tick(tick_x), .sell_bus(bus_h),
      .price_a(pa_h), .price_b(pb_h), .qty_a(qa_h), .qty_b(qb_h), .cash(cash_h),
      .trade_done(done_h), .trade_reject(rej_h), .price_upd(upd_h), .tick_overrun(ovr_h)
`ifdef MARKET_TRADE_STATS_EN
      , .trades_ok(ok_h), .trades_rej(nrej_h)
`endif
   );

   market_trade_sequencer #(.INIT_PRICE(1)) u_lo (
      .clock_50(clock_50), .reset(reset), .tick(tick_x), .sell_bus(bus_l),
      .price_a(pa_l), .price_b(pb_l), .qty_a(qa_l), .qty_b(qb_l), .cash(cash_l),
      .trade_done(done_l), .trade_reject(rej_l), .price_upd(upd_l), .tick_overrun(ovr_l)
`ifdef MARKET_TRADE_STATS_EN
      , .trades_ok(ok_l), .trades_rej(nrej_l)
`endif
   );

   // Reference LFSR: taps 16,14,13,11 expressed as a bit mask.
   logic [15:0] m_lfsr;
   always @(posedge clock_50) begin
      if (reset) m_lfsr <= 16'hACE1;
      else       m_lfsr <= {m_lfsr[14:0], ^(m_lfsr & 16'hB400)};
   end

   int n_chk = 0;
   int n_err = 0;
   int mpa[3], mpb[3], mlo[3], mhi[3];
   int mqa, mqb, mcash;
   int n_ok_m = 0, n_rej_m = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int model_step(input int p, input logic [15:0] l, input int lo, input int hi);
      int adj;
      adj = int'(l) % 32;
      if (l[15]) begin
         p = p - adj;
         if (p < lo) p = lo;
      end else begin
         p = p + adj;
         if (p > hi) p = hi;
      end
      return p;
   endfunction

   task automatic sell_main(input logic stock, input int amt, input bit ok);
      @(negedge clock_50);
      bus_m.sell_valid = 1'b1;
      bus_m.sell_stock = stock;
      bus_m.sell_amt   = 8'(amt);
      #1 check("sell_ready", 32'(bus_m.sell_ready), 1);
      @(posedge clock_50);
      @(negedge clock_50);
      bus_m.sell_valid = 1'b0;
      @(posedge clock_50); #1;
      check("reject_e1", 32'(rej_m), 32'(!ok));
      check("done_e1", 32'(done_m), 0);
      @(posedge clock_50); #1;
      if (ok) begin
         if (stock) begin mqb -= amt; mcash += amt * mpb[0]; end
         else       begin mqa -= amt; mcash += amt * mpa[0]; end
         if (mcash > c_CASH_MAX) mcash = c_CASH_MAX;
         n_ok_m++;
         check("done_e2", 32'(done_m), 1);
      end else begin
         n_rej_m++;
         check("reject_off", 32'(rej_m), 0);
      end
      check("qty_a", 32'(qa_m), 32'(mqa));
      check("qty_b", 32'(qb_m), 32'(mqb));
      check("cash", 32'(cash_m), 32'(mcash));
      @(posedge clock_50); #1;
      check("done_single", 32'(done_m), 0);
      check("reject_single", 32'(rej_m), 0);
   endtask

   task automatic aux_tick();
      logic [15:0] la, lb;
      @(negedge clock_50); tick_x = 1'b1;
      @(posedge clock_50); #1 la = m_lfsr;
      @(negedge clock_50); tick_x = 1'b0;
      @(posedge clock_50); #1 lb = m_lfsr;
      @(posedge clock_50); #1;
      for (int k = 1; k < 3; k++) begin
         mpa[k] = model_step(mpa[k], la, mlo[k], mhi[k]);
         mpb[k] = model_step(mpb[k], lb, mlo[k], mhi[k]);
      end
      check("hi_pa", 32'(pa_h), 32'(mpa[1]));
      check("hi_pb", 32'(pb_h), 32'(mpb[1]));
      check("lo_pa", 32'(pa_l), 32'(mpa[2]));
      check("lo_pb", 32'(pb_l), 32'(mpb[2]));
      check("hi_ceiling", 32'(pa_h <= 12'd255 && pb_h <= 12'd255), 1);
      check("lo_floor", 32'(pa_l >= 12'd1 && pb_l >= 12'd1), 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [15:0] la, lb;
      bus_m.sell_valid = 1'b0; bus_m.sell_stock = 1'b0; bus_m.sell_amt = '0;
      bus_h.sell_valid = 1'b0; bus_h.sell_stock = 1'b0; bus_h.sell_amt = '0;
      bus_l.sell_valid = 1'b0; bus_l.sell_stock = 1'b0; bus_l.sell_amt = '0;
      mpa[0] = 100; mpb[0] = 100; mlo[0] = 1; mhi[0] = 255;
      mpa[1] = 255; mpb[1] = 255; mlo[1] = 1; mhi[1] = 255;
      mpa[2] = 1;   mpb[2] = 1;   mlo[2] = 1; mhi[2] = 255;
      mqa = 50; mqb = 50; mcash = 1000;

      repeat (3) @(posedge clock_50);
      @(negedge clock_50); reset = 1'b0;

      // Reset state
      check("rst_price_a", 32'(pa_m), 100);
      check("rst_price_b", 32'(pb_m), 100);
      check("rst_qty_a", 32'(qa_m), 50);
      check("rst_qty_b", 32'(qb_m), 50);
      check("rst_cash", 32'(cash_m), 1000);
      check("rst_pulses", 32'({done_m, rej_m, upd_m, ovr_m}), 0);
      check("rst_ready", 32'(bus_m.sell_ready), 1);
      check("rst_hi_price", 32'(pa_h), 255);
      check("rst_lo_price", 32'(pb_l), 1);

      // Basic trade and the two reject cases
      sell_main(1'b0, 10, 1'b1);
      check("price_a_kept", 32'(pa_m), 100);
      sell_main(1'b1, 51, 1'b0);
      sell_main(1'b0, 0, 1'b0);

      // Tick and sell in the same cycle: tick wins, sell waits
      @(negedge clock_50);
      tick_m = 1'b1;
      bus_m.sell_valid = 1'b1; bus_m.sell_stock = 1'b1; bus_m.sell_amt = 8'd5;
      #1 check("ready_tick", 32'(bus_m.sell_ready), 0);
      @(posedge clock_50); #1 la = m_lfsr;
      @(negedge clock_50); tick_m = 1'b0;
      check("ready_price_a", 32'(bus_m.sell_ready), 0);
      @(posedge clock_50); #1 lb = m_lfsr;
      @(posedge clock_50); #1;
      mpa[0] = model_step(mpa[0], la, 1, 255);
      mpb[0] = model_step(mpb[0], lb, 1, 255);
      check("step_price_a", 32'(pa_m), 32'(mpa[0]));
      check("step_price_b", 32'(pb_m), 32'(mpb[0]));
      check("price_upd_on", 32'(upd_m), 1);
      check("ready_after_step", 32'(bus_m.sell_ready), 1);
      @(posedge clock_50); #1;
      check("price_upd_off", 32'(upd_m), 0);
      @(negedge clock_50); bus_m.sell_valid = 1'b0;
      @(posedge clock_50);
      @(posedge clock_50); #1;
      mqb -= 5; mcash += 5 * mpb[0]; n_ok_m++;
      check("held_done", 32'(done_m), 1);
      check("held_qty_b", 32'(qb_m), 32'(mqb));
      check("held_cash", 32'(cash_m), 32'(mcash));

      // Three back-to-back ticks during a trade: one pending, one dropped, one merged
      @(negedge clock_50);
      bus_m.sell_valid = 1'b1; bus_m.sell_stock = 1'b0; bus_m.sell_amt = 8'd5;
      @(posedge clock_50);
      @(negedge clock_50); bus_m.sell_valid = 1'b0; tick_m = 1'b1;
      @(posedge clock_50); #1;
      check("ovr_after_first", 32'(ovr_m), 0);
      @(posedge clock_50); #1;
      mqa -= 5; mcash += 5 * mpa[0]; n_ok_m++;
      check("ovr_done", 32'(done_m), 1);
      check("ovr_cash", 32'(cash_m), 32'(mcash));
      check("ovr_set", 32'(ovr_m), 1);
      @(posedge clock_50); #1 la = m_lfsr;
      @(negedge clock_50); tick_m = 1'b0;
      @(posedge clock_50); #1 lb = m_lfsr;
      @(posedge clock_50); #1;
      mpa[0] = model_step(mpa[0], la, 1, 255);
      mpb[0] = model_step(mpb[0], lb, 1, 255);
      check("pend_price_a", 32'(pa_m), 32'(mpa[0]));
      check("pend_price_b", 32'(pb_m), 32'(mpb[0]));
      check("pend_upd", 32'(upd_m), 1);
      for (int i = 0; i < 6; i++) begin
         @(posedge clock_50); #1;
         check("no_extra_upd", 32'(upd_m), 0);
      end
      check("ovr_sticky", 32'(ovr_m), 1);
      check("quiet_price_a", 32'(pa_m), 32'(mpa[0]));

      // Cash saturation on the high-price instance
      @(negedge clock_50);
      bus_h.sell_valid = 1'b1; bus_h.sell_stock = 1'b0; bus_h.sell_amt = 8'd50;
      @(posedge clock_50);
      @(negedge clock_50); bus_h.sell_valid = 1'b0;
      @(posedge clock_50); @(posedge clock_50); #1;
      check("hi_done_a", 32'(done_h), 1);
      check("hi_cash_a", 32'(cash_h), 32'(c_HI_CASH0 + 12750));
      @(negedge clock_50);
      bus_h.sell_valid = 1'b1; bus_h.sell_stock = 1'b1; bus_h.sell_amt = 8'd50;
      @(posedge clock_50);
      @(negedge clock_50); bus_h.sell_valid = 1'b0;
      @(posedge clock_50); @(posedge clock_50); #1;
      check("hi_cash_sat", 32'(cash_h), 32'(c_CASH_MAX));
      check("hi_qty_b", 32'(qb_h), 0);
      @(negedge clock_50);
      bus_h.sell_valid = 1'b1; bus_h.sell_stock = 1'b0; bus_h.sell_amt = 8'd1;
      @(posedge clock_50);
      @(negedge clock_50); bus_h.sell_valid = 1'b0;
      @(posedge clock_50); #1;
      check("hi_reject_empty", 32'(rej_h), 1);
      @(posedge clock_50); #1;
      check("hi_cash_hold", 32'(cash_h), 32'(c_CASH_MAX));

      // Long random walk against both saturation bounds
      for (int t = 0; t < 1000; t++) aux_tick();

`ifdef MARKET_TRADE_STATS_EN
      check("stats_ok_m", 32'(ok_m), 32'(n_ok_m));
      check("stats_rej_m", 32'(nrej_m), 32'(n_rej_m));
      check("stats_ok_h", 32'(ok_h), 2);
      check("stats_rej_h", 32'(nrej_h), 1);
      check("stats_ok_l", 32'(ok_l), 0);
`endif

      // Reset during an in-flight trade discards it
      @(negedge clock_50);
      bus_m.sell_valid = 1'b1; bus_m.sell_stock = 1'b0; bus_m.sell_amt = 8'd3;
      @(posedge clock_50);
      @(negedge clock_50); bus_m.sell_valid = 1'b0; reset = 1'b1;
      @(posedge clock_50); #1;
      check("mid_rst_qty_a", 32'(qa_m), 50);
      check("mid_rst_cash", 32'(cash_m), 1000);
      check("mid_rst_ovr", 32'(ovr_m), 0);
      check("mid_rst_price", 32'(pb_m), 100);
      @(negedge clock_50); reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clock_50); #1;
         check("mid_rst_no_done", 32'(done_m), 0);
      end
      check("mid_rst_qty_kept", 32'(qa_m), 50);
`ifdef MARKET_TRADE_STATS_EN
      check("stats_rst_ok", 32'(ok_m), 0);
      check("stats_rst_rej", 32'(nrej_h), 0);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
